// File: rtl/pll_dyn_ctrl.sv
// Dynamic PLL divider-set controller: applies a selected mode, pulses pll_reset, waits for a stable lock, retries on timeout.
// Optional macro PLL_LOCK_MON_EN: in IDLE, two consecutive pll_lock-low cycles trigger an automatic relock.
module pll_dyn_ctrl #(
    parameter int NUM_MODES    = 4,
    parameter int DEFAULT_MODE = 0,
    parameter logic [6*NUM_MODES-1:0] MODE_IDSEL  = '0,
    parameter logic [6*NUM_MODES-1:0] MODE_FBDSEL = '0,
    parameter logic [6*NUM_MODES-1:0] MODE_ODSEL  = '0,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE  = 8,
    parameter int MAX_RETRY    = 3,
    localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [MODE_W-1:0] req_mode,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [5:0]        idsel,
    output logic [5:0]        fbdsel,
    output logic [5:0]        odsel,
    output logic              busy,
    output logic              locked,
    output logic              err,
    output logic [MODE_W-1:0] cur_mode
);

    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int STB_W = $clog2(LOCK_STABLE + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {IDLE, RST, WAIT_LOCK, FAIL} state_t;

    function automatic logic [5:0] sel_of(input logic [6*NUM_MODES-1:0] tbl, input int idx);
        return tbl[6*idx +: 6];
    endfunction

    state_t            state_q;
    logic [RST_W-1:0]  rst_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic [STB_W-1:0]  stb_cnt_q;
    logic [RTY_W-1:0]  retry_q;
    logic              pll_reset_q;
    logic              locked_q;
    logic              err_q;
    logic [MODE_W-1:0] mode_q;
    logic [5:0]        idsel_q;
    logic [5:0]        fbdsel_q;
    logic [5:0]        odsel_q;
`ifdef PLL_LOCK_MON_EN
    logic              low_q;
`endif

    logic req_fire;
    logic req_in_range;

    assign req_ready    = (state_q == IDLE) || (state_q == FAIL);
    assign busy         = (state_q == RST) || (state_q == WAIT_LOCK);
    assign req_fire     = req_valid && req_ready;
    assign req_in_range = 32'(req_mode) < 32'(NUM_MODES);

    assign pll_reset = pll_reset_q;
    assign locked    = locked_q;
    assign err       = err_q;
    assign cur_mode  = mode_q;
    assign idsel     = idsel_q;
    assign fbdsel    = fbdsel_q;
    assign odsel     = odsel_q;

    // Reset parks the FSM in RST with a zero count, so releasing reset starts the default-mode lock.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= RST;
            rst_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            stb_cnt_q   <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            mode_q      <= MODE_W'(DEFAULT_MODE);
            idsel_q     <= sel_of(MODE_IDSEL, DEFAULT_MODE);
            fbdsel_q    <= sel_of(MODE_FBDSEL, DEFAULT_MODE);
            odsel_q     <= sel_of(MODE_ODSEL, DEFAULT_MODE);
`ifdef PLL_LOCK_MON_EN
            low_q       <= 1'b0;
`endif
        end else begin
`ifdef PLL_LOCK_MON_EN
            low_q <= 1'b0;
`endif
            case (state_q)
                IDLE, FAIL: begin
                    if (req_fire) begin
                        if (req_in_range) begin
                            mode_q      <= req_mode;
                            idsel_q     <= sel_of(MODE_IDSEL, int'(req_mode));
                            fbdsel_q    <= sel_of(MODE_FBDSEL, int'(req_mode));
                            odsel_q     <= sel_of(MODE_ODSEL, int'(req_mode));
                            err_q       <= 1'b0;
                            locked_q    <= 1'b0;
                            retry_q     <= '0;
                            rst_cnt_q   <= '0;
                            pll_reset_q <= 1'b1;
                            state_q     <= RST;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else if (state_q == IDLE && locked_q && !pll_lock) begin
`ifdef PLL_LOCK_MON_EN
                        if (low_q) begin
                            locked_q    <= 1'b0;
                            retry_q     <= '0;
                            rst_cnt_q   <= '0;
                            pll_reset_q <= 1'b1;
                            state_q     <= RST;
                        end else begin
                            low_q <= 1'b1;
                        end
`else
                        locked_q <= 1'b0;
`endif
                    end
                end
                RST: begin
                    if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
                        pll_reset_q <= 1'b0;
                        tmo_cnt_q   <= '0;
                        stb_cnt_q   <= '0;
                        state_q     <= WAIT_LOCK;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    stb_cnt_q <= pll_lock ? stb_cnt_q + 1'b1 : '0;
                    // A lock completing on the timeout cycle wins over the timeout.
                    if (pll_lock && stb_cnt_q == STB_W'(LOCK_STABLE - 1)) begin
                        locked_q <= 1'b1;
                        state_q  <= IDLE;
                    end else if (tmo_cnt_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
                        pll_reset_q <= 1'b1;
                        if (retry_q < RTY_W'(MAX_RETRY)) begin
                            retry_q   <= retry_q + 1'b1;
                            rst_cnt_q <= '0;
                            state_q   <= RST;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= FAIL;
                        end
                    end
                end
                default: state_q <= RST;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Bench for pll_dyn_ctrl: reset values, power-up lock, mode-switch vector table, randomized lock waveforms, lock loss, timeout/FAIL and reset abort.
module tb_pll_dyn_ctrl;

    localparam int NM   = 3;
    localparam int RSTC = 16;
    localparam int TMO  = 100;
    localparam int STB  = 8;
    localparam int RTY  = 3;
    localparam logic [17:0] T_ID = {6'h2A, 6'h11, 6'h05};
    localparam logic [17:0] T_FB = {6'h3F, 6'h21, 6'h0C};
    localparam logic [17:0] T_OD = {6'h33, 6'h02, 6'h01};

    logic       clkin = 1'b0;
    logic       reset, req_valid, req_ready, pll_lock, pll_reset, busy, locked, err;
    logic [1:0] req_mode, cur_mode;
    logic [5:0] idsel, fbdsel, odsel;

    int n_tests   = 0;
    int n_fail    = 0;
    int bad_ready = 0;
    bit wave [64];
    logic [5:0] ref_id [NM];
    logic [5:0] ref_fb [NM];
    logic [5:0] ref_od [NM];

    always #5 clkin = ~clkin;

    pll_dyn_ctrl #(
        .NUM_MODES(NM), .DEFAULT_MODE(0),
        .MODE_IDSEL(T_ID), .MODE_FBDSEL(T_FB), .MODE_ODSEL(T_OD),
        .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TMO), .LOCK_STABLE(STB), .MAX_RETRY(RTY)
    ) dut (
        .clkin(clkin), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .pll_lock(pll_lock), .pll_reset(pll_reset),
        .idsel(idsel), .fbdsel(fbdsel), .odsel(odsel),
        .busy(busy), .locked(locked), .err(err), .cur_mode(cur_mode)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic check_mode(input string name, input int m);
        check({name, "_cur_mode"}, 32'(cur_mode), m);
        check({name, "_idsel"}, 32'(idsel), 32'(ref_id[m]));
        check({name, "_fbdsel"}, 32'(fbdsel), 32'(ref_fb[m]));
        check({name, "_odsel"}, 32'(odsel), 32'(ref_od[m]));
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_pll_reset"}, 32'(pll_reset), 1);
        check({name, "_busy"}, 32'(busy), 1);
        check({name, "_locked"}, 32'(locked), 0);
        check({name, "_err"}, 32'(err), 0);
        check({name, "_req_ready"}, 32'(req_ready), 0);
        check_mode(name, 0);
    endtask

    task automatic do_request(input logic [1:0] m);
        req_mode  = m;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Counts cycles with pll_reset high, starting with the current sample.
    task automatic pulse_len(output int n, input bit rand_lock);
        n = 0;
        while (pll_reset === 1'b1 && n < 1000) begin
            if (req_ready !== 1'b0) bad_ready++;
            if (rand_lock) pll_lock = 1'($urandom_range(0, 1));
            n++;
            tick();
        end
    endtask

    function automatic bit wave_at(input int i);
        return (i < 64) ? wave[i] : 1'b1;
    endfunction

    // Cycles from WAIT_LOCK entry until the first moment the last STB sampled values are all high.
    function automatic int exp_lock();
        bit all1;
        for (int t = STB - 1; t < 200; t++) begin
            all1 = 1'b1;
            for (int k = 0; k < STB; k++)
                if (!wave_at(t - k)) all1 = 1'b0;
            if (all1) return t + 1;
        end
        return -1;
    endfunction

    task automatic run_wave(output int ticks);
        ticks = -1;
        for (int i = 0; i < 200; i++) begin
            pll_lock = wave_at(i);
            tick();
            if (locked === 1'b1) begin
                ticks = i + 1;
                break;
            end
            if (req_ready !== 1'b0) bad_ready++;
        end
    endtask

    task automatic clean_wave(input int d);
        for (int i = 0; i < 64; i++) wave[i] = (i >= d);
    endtask

    task automatic full_lock(input string name, input bit rand_lock);
        int n;
        pulse_len(n, rand_lock);
        req_valid = 1'b0;
        check({name, "_pulse"}, n, RSTC);
        run_wave(n);
        check({name, "_lock_lat"}, n, exp_lock());
    endtask

    typedef struct packed {
        logic [1:0] mode;
        logic       exp_err;
        logic [1:0] exp_cm;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int   n, cm, m, len, pulses, wait_cyc, cyc;
        bit   prev, saw_lock;

        ref_id = '{6'h05, 6'h11, 6'h2A};
        ref_fb = '{6'h0C, 6'h21, 6'h3F};
        ref_od = '{6'h01, 6'h02, 6'h33};
        vecs[0] = '{2'd2, 1'b0, 2'd2};
        vecs[1] = '{2'd3, 1'b1, 2'd2};
        vecs[2] = '{2'd1, 1'b0, 2'd1};
        vecs[3] = '{2'd0, 1'b0, 2'd0};
        vecs[4] = '{2'd3, 1'b1, 2'd0};
        vecs[5] = '{2'd2, 1'b0, 2'd2};

        reset = 1'b1; req_valid = 1'b0; req_mode = 2'd0; pll_lock = 1'b0;
        repeat (3) tick();
        check_reset_vals("reset");

        // Power-up: default mode locks, pll_lock rises 20 cycles after pll_reset falls.
        reset = 1'b0;
        pulse_len(n, 1'b0);
        check("por_pulse", n, RSTC);
        clean_wave(20);
        run_wave(n);
        check("por_lock_lat", n, 20 + STB);
        check("por_busy", 32'(busy), 0);
        check("por_ready", 32'(req_ready), 1);
        check("por_err", 32'(err), 0);
        check_mode("por", 0);

        // Mode-switch vector table, including out-of-range requests.
        for (int i = 0; i < 6; i++) begin
            pll_lock = vecs[i].exp_err;
            do_request(vecs[i].mode);
            check("vec_err", 32'(err), 32'(vecs[i].exp_err));
            check_mode("vec", int'(vecs[i].exp_cm));
            if (!vecs[i].exp_err) begin
                check("vec_pll_reset", 32'(pll_reset), 1);
                check("vec_ready", 32'(req_ready), 0);
                check("vec_locked", 32'(locked), 0);
                clean_wave(i * 3);
                full_lock("vec", 1'b0);
                check("vec_locked_end", 32'(locked), 1);
            end else begin
                check("vec_oor_pll_reset", 32'(pll_reset), 0);
                check("vec_oor_ready", 32'(req_ready), 1);
                check("vec_oor_busy", 32'(busy), 0);
            end
        end

        // Randomized requests and lock waveforms against the window model.
        cm = 2;
        for (int it = 0; it < 25; it++) begin
            m = int'($urandom_range(0, 3));
            pll_lock = (m >= NM);
            do_request(2'(m));
            if (m >= NM) begin
                check("rnd_oor_err", 32'(err), 1);
                check("rnd_oor_pll_reset", 32'(pll_reset), 0);
                check_mode("rnd_oor", cm);
            end else begin
                cm = m;
                check("rnd_err", 32'(err), 0);
                check_mode("rnd_req", cm);
                // A request raised while busy must be ignored.
                req_valid = 1'b1;
                req_mode  = 2'($urandom_range(0, 2));
                len = int'($urandom_range(0, 40));
                for (int i = 0; i < 64; i++)
                    wave[i] = (i < len) ? ($urandom_range(0, 3) != 0) : 1'b1;
                full_lock("rnd", 1'b1);
                check_mode("rnd_locked", cm);
            end
        end

        // Lock loss while locked in IDLE.
        pll_lock = 1'b0;
        tick();
`ifdef PLL_LOCK_MON_EN
        check("ll_first_low_locked", 32'(locked), 1);
        tick();
        pll_lock = 1'b1;
        check("ll_pll_reset", 32'(pll_reset), 1);
        check("ll_busy", 32'(busy), 1);
        check("ll_locked", 32'(locked), 0);
        check_mode("ll", cm);
        clean_wave(0);
        full_lock("ll", 1'b0);
        check("ll_relocked", 32'(locked), 1);
`else
        check("ll_locked", 32'(locked), 0);
        tick();
        pll_lock = 1'b1;
        repeat (5) tick();
        check("ll_pll_reset", 32'(pll_reset), 0);
        check("ll_busy", 32'(busy), 0);
        check("ll_locked_stays", 32'(locked), 0);
        check("ll_ready", 32'(req_ready), 1);
`endif

        // Glitchy lock (5 high / 1 low) never locks: 4 attempts, then FAIL.
        pll_lock = 1'b0;
        prev = 1'b0; pulses = 0; wait_cyc = 0; cyc = 0; saw_lock = 1'b0;
        do_request(2'd1);
        while (busy === 1'b1 && cyc < 1000) begin
            if (pll_reset && !prev) pulses++;
            if (!pll_reset) wait_cyc++;
            if (locked) saw_lock = 1'b1;
            prev = pll_reset;
            pll_lock = ((cyc % 6) < 5);
            cyc++;
            tick();
        end
        check("to_pulses", pulses, RTY + 1);
        check("to_wait_cycles", wait_cyc, (RTY + 1) * TMO);
        check("to_never_locked", 32'(saw_lock), 0);
        repeat (3) tick();
        check("fail_err", 32'(err), 1);
        check("fail_pll_reset", 32'(pll_reset), 1);
        check("fail_locked", 32'(locked), 0);
        check("fail_ready", 32'(req_ready), 1);
        check("fail_busy", 32'(busy), 0);

        // Recovery from FAIL with a valid request.
        pll_lock = 1'b0;
        do_request(2'd2);
        check("rec_err", 32'(err), 0);
        check("rec_busy", 32'(busy), 1);
        check_mode("rec", 2);
        clean_wave(5);
        full_lock("rec", 1'b0);

        // Reset asserted mid-WAIT_LOCK aborts, then default mode auto-locks.
        pll_lock = 1'b0;
        do_request(2'd1);
        pulse_len(n, 1'b0);
        check("ab_pulse", n, RSTC);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check_reset_vals("abort");
        reset = 1'b0;
        clean_wave(3);
        full_lock("ab_relock", 1'b0);
        check_mode("ab_relock", 0);

        check("ready_while_busy", bad_ready, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
